// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding / hazard unit.
// Select encoding and default register / latency widths.
package fwd_hazard_unit_pkg;

  localparam int PKG_REG_AW     = 5;
  localparam int PKG_LAT_W      = 3;
  localparam int LAT_MAX        = 2**PKG_LAT_W - 1;
  localparam int FWD_RF         = 0;
  localparam int FWD_STAGE_BASE = 1;

endpackage

// File: rtl/fwd_hazard_unit_sb_counter.sv
// Single-register long-latency countdown.
// Issue takes the max of the decremented count and the new latency.
module sb_counter
  import fwd_hazard_unit_pkg::*;
#(
  parameter int LAT_W = PKG_LAT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic             busy_o
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;
  logic [LAT_W-1:0] dec;

  always_comb begin
    dec   = (cnt_q == '0) ? '0 : cnt_q - LAT_W'(1);
    cnt_d = dec;
    // max keeps an older, longer write pending (WAW)
    if (issue_i && (lat_i > dec)) begin
      cnt_d = lat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass select, load-use and scoreboard stall,
// with a saturating stall-cycle counter.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = PKG_REG_AW,
  parameter int LAT_W   = PKG_LAT_W,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = $clog2(NUM_FWD+1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs_i,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic                      idex_memread_i,
  input  logic [REG_AW-1:0]         idex_rd_i,
  input  logic                      mc_issue_i,
  input  logic [REG_AW-1:0]         mc_rd_i,
  input  logic [LAT_W-1:0]          mc_lat_i,
  output logic                      stall_o,
  output logic [2**REG_AW-1:0]      sb_busy_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  localparam int NREG = 2**REG_AW;

  logic            lu_hit;
  logic            sb_hit;
  logic            mc_vld;
  logic [NREG-1:0] busy;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd_sel_o = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      fwd_sel_o[j*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
      for (int k = NUM_FWD-1; k >= 0; k--) begin
        if (fwd_we_i[k] &&
            (fwd_rd_i[k*REG_AW +: REG_AW] != '0) &&
            (fwd_rd_i[k*REG_AW +: REG_AW] ==
             ex_rs_i[j*REG_AW +: REG_AW])) begin
          fwd_sel_o[j*SEL_W +: SEL_W] =
            SEL_W'(FWD_STAGE_BASE + k);
        end
      end
    end
  end

  assign mc_vld = mc_issue_i && (mc_rd_i != '0);

  always_comb begin
    lu_hit = 1'b0;
    sb_hit = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (id_rs_used_i[j]) begin
        if (idex_memread_i &&
            (idex_rd_i != '0) &&
            (id_rs_i[j*REG_AW +: REG_AW] == idex_rd_i)) begin
          lu_hit = 1'b1;
        end
        if (busy[id_rs_i[j*REG_AW +: REG_AW]] ||
            (mc_vld &&
             (id_rs_i[j*REG_AW +: REG_AW] == mc_rd_i))) begin
          sb_hit = 1'b1;
        end
      end
    end
  end

  assign stall_o = lu_hit || sb_hit;

  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    sb_counter #(
      .LAT_W (LAT_W)
    ) u_sb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .issue_i (mc_vld && (mc_rd_i == REG_AW'(r))),
      .lat_i   (mc_lat_i),
      .busy_o  (busy[r])
    );
  end

  assign sb_busy_o = busy;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: release-time scoreboard model,
// two instances (32-bit and 4-bit stall counters).
module tb_fwd_hazard_unit;
  import fwd_hazard_unit_pkg::*;

  localparam int NS = 2;
  localparam int NF = 2;
  localparam int AW = 5;
  localparam int LW = 3;
  localparam int SW = 2;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NF-1:0]    fwd_we = '0;
  logic [NF*AW-1:0] fwd_rd = '0;
  logic [NS*AW-1:0] ex_rs = '0;
  logic [NS*AW-1:0] id_rs = '0;
  logic [NS-1:0]    used = '0;
  logic          memrd = 1'b0;
  logic [AW-1:0] idex_rd = '0;
  logic          mc_issue = 1'b0;
  logic [AW-1:0] mc_rd = '0;
  logic [LW-1:0] mc_lat = '0;

  logic [NS*SW-1:0] sel_a, sel_b;
  logic          stall_a, stall_b;
  logic [NR-1:0] busy_a, busy_b;
  logic [31:0]   cnt_a;
  logic [3:0]    cnt_b;

  int nchk = 0;
  int nerr = 0;
  bit run = 1'b0;

  int          cyc = 0;
  int          rel [NR];
  logic [31:0] m_cnt32 = '0;
  logic [3:0]  m_cnt4 = '0;
  logic [NR-1:0] eb;

  fwd_hazard_unit #(
    .NUM_SRC(NS), .NUM_FWD(NF), .REG_AW(AW),
    .LAT_W(LW), .CNT_W(32)
  ) dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .fwd_we_i(fwd_we), .fwd_rd_i(fwd_rd),
    .ex_rs_i(ex_rs), .fwd_sel_o(sel_a),
    .id_rs_i(id_rs), .id_rs_used_i(used),
    .idex_memread_i(memrd), .idex_rd_i(idex_rd),
    .mc_issue_i(mc_issue), .mc_rd_i(mc_rd),
    .mc_lat_i(mc_lat), .stall_o(stall_a),
    .sb_busy_o(busy_a), .stall_cnt_o(cnt_a)
  );

  fwd_hazard_unit #(
    .NUM_SRC(NS), .NUM_FWD(NF), .REG_AW(AW),
    .LAT_W(LW), .CNT_W(4)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .fwd_we_i(fwd_we), .fwd_rd_i(fwd_rd),
    .ex_rs_i(ex_rs), .fwd_sel_o(sel_b),
    .id_rs_i(id_rs), .id_rs_used_i(used),
    .idex_memread_i(memrd), .idex_rd_i(idex_rd),
    .mc_issue_i(mc_issue), .mc_rd_i(mc_rd),
    .mc_lat_i(mc_lat), .stall_o(stall_b),
    .sb_busy_o(busy_b), .stall_cnt_o(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] m_sel(int j);
    logic [AW-1:0] rs;
    logic [AW-1:0] rd;
    rs = ex_rs[j*AW +: AW];
    for (int k = 0; k < NF; k++) begin
      rd = fwd_rd[k*AW +: AW];
      if (fwd_we[k] && rd != 0 && rd == rs)
        return SW'(k + 1);
    end
    return '0;
  endfunction

  // register r is busy while its latest release lies ahead
  function automatic bit m_busy(int r);
    return (r != 0) && (rel[r] > cyc);
  endfunction

  function automatic bit m_stall();
    logic [AW-1:0] rs;
    bit hit;
    hit = 1'b0;
    for (int j = 0; j < NS; j++) begin
      rs = id_rs[j*AW +: AW];
      if (used[j]) begin
        if (memrd && idex_rd != 0 && rs == idex_rd) hit = 1'b1;
        if (m_busy(int'(rs))) hit = 1'b1;
        if (mc_issue && mc_rd != 0 && rs == mc_rd) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NR; r++) rel[r] = 0;
    m_cnt32 = '0;
    m_cnt4 = '0;
  endtask

  always @(negedge rst_n) m_clear();

  always @(posedge clk) begin
    if (!rst_n) begin
      m_clear();
    end else begin
      if (m_stall()) begin
        if (m_cnt32 != 32'hffff_ffff) m_cnt32 = m_cnt32 + 1;
        if (m_cnt4 != 4'hf) m_cnt4 = m_cnt4 + 1;
      end
      cyc = cyc + 1;
      if (mc_issue && mc_rd != 0) begin
        if (cyc + int'(mc_lat) > rel[mc_rd])
          rel[mc_rd] = cyc + int'(mc_lat);
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int r = 0; r < NR; r++) eb[r] = m_busy(r);
      for (int j = 0; j < NS; j++) begin
        chk("sel_a", sel_a[j*SW +: SW], m_sel(j));
        chk("sel_b", sel_b[j*SW +: SW], m_sel(j));
      end
      chk("stall_a", stall_a, m_stall());
      chk("stall_b", stall_b, m_stall());
      chk("busy_a", busy_a, eb);
      chk("busy_b", busy_b, eb);
      chk("cnt_a", cnt_a, m_cnt32);
      chk("cnt_b", cnt_b, m_cnt4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fwd_we = '0; fwd_rd = '0; ex_rs = '0;
    id_rs = '0; used = '0; memrd = 1'b0;
    idex_rd = '0; mc_issue = 1'b0; mc_rd = '0; mc_lat = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int r = 0; r < NR; r++) rel[r] = 0;
    #1 rst_n = 1'b0;
    step();
    run = 1'b1;
    chk("rst_busy", busy_a, '0);
    chk("rst_cnt", cnt_a, '0);
    step();
    rst_n = 1'b1;

    // forwarding priority
    fwd_we = 2'b11;
    fwd_rd = {5'd5, 5'd5};
    ex_rs = {5'd6, 5'd5};
    #1;
    chk("fwd_young", sel_a[1:0], 2'd1);
    chk("fwd_none", sel_a[3:2], 2'd0);
    fwd_we = 2'b10;
    #1;
    chk("fwd_old", sel_a[1:0], 2'd2);
    fwd_we = 2'b11;
    fwd_rd = {5'd0, 5'd0};
    ex_rs = {5'd0, 5'd0};
    #1;
    chk("fwd_x0", sel_a, '0);
    step();

    // load-use single cycle
    do_reset();
    memrd = 1'b1; idex_rd = 5'd7;
    id_rs = {5'd0, 5'd7}; used = 2'b01;
    #1;
    chk("lu_stall", stall_a, 1'b1);
    step();
    memrd = 1'b0;
    #1;
    chk("lu_clear", stall_a, 1'b0);
    chk("lu_cnt", cnt_a, 32'd1);
    memrd = 1'b1; used = 2'b00;
    #1;
    chk("lu_unused", stall_a, 1'b0);
    step();
    chk("lu_cnt_hold", cnt_a, 32'd1);

    // scoreboard x9 lat 3
    do_reset();
    mc_issue = 1'b1; mc_rd = 5'd9; mc_lat = 3'd3;
    id_rs = {5'd0, 5'd9}; used = 2'b01;
    #1;
    chk("sb_same_cyc", stall_a, 1'b1);
    step();
    mc_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sb_busy9", busy_a[9], 1'b1);
      chk("sb_stall", stall_a, 1'b1);
      step();
    end
    chk("sb_free9", busy_a[9], 1'b0);
    chk("sb_nostall", stall_a, 1'b0);
    chk("sb_cnt4", cnt_a, 32'd4);

    // WAW max
    do_reset();
    mc_issue = 1'b1; mc_rd = 5'd4; mc_lat = 3'd5;
    step();
    mc_issue = 1'b0;
    step();
    mc_issue = 1'b1; mc_lat = 3'd1;
    step();
    mc_issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("waw_busy4", busy_a[4], 1'b1);
      step();
    end
    chk("waw_free4", busy_a[4], 1'b0);

    // asynchronous reset mid-countdown
    do_reset();
    mc_issue = 1'b1; mc_rd = 5'd3; mc_lat = 3'd7;
    id_rs = {5'd0, 5'd3}; used = 2'b01;
    step();
    mc_issue = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, '0);
    chk("arst_cnt", cnt_a, '0);
    step();
    rst_n = 1'b1;
    #1;
    chk("arst_x3", stall_a, 1'b0);
    step();

    // saturation of the 4-bit counter
    do_reset();
    memrd = 1'b1; idex_rd = 5'd7;
    id_rs = {5'd0, 5'd7}; used = 2'b01;
    repeat (20) step();
    chk("sat_cnt4", cnt_b, 4'hf);
    chk("sat_cnt32", cnt_a, 32'd20);
    idle();
    step();

    // mixed traffic against the model
    for (int i = 0; i < 80; i++) begin
      fwd_we = 2'($urandom_range(3));
      fwd_rd = {5'($urandom_range(7)), 5'($urandom_range(7))};
      ex_rs = {5'($urandom_range(7)), 5'($urandom_range(7))};
      id_rs = {5'($urandom_range(7)), 5'($urandom_range(7))};
      used = 2'($urandom_range(3));
      memrd = ($urandom_range(3) == 0);
      idex_rd = 5'($urandom_range(7));
      mc_issue = ($urandom_range(2) == 0);
      mc_rd = 5'($urandom_range(7));
      mc_lat = 3'($urandom_range(LAT_MAX, 1));
      step();
    end
    idle();
    step();
    step();

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-operand forwarding logic.
- Resolves operand bypass for NUM_SRC EX-stage sources across NUM_FWD later pipeline stages.
- Detects load-use hazards in ID.
- Keeps a per-register scoreboard for long-latency (mul/div) writebacks, with a saturating stall-cycle performance counter.
- Sits beside the hazard-detection path between the ID/EX and EX/MEM pipeline registers and drives operand muxes plus the global stall.

Parameters:
- NUM_SRC, 2, source operands per instruction (rs1, rs2[, rs3]).
- NUM_FWD, 2, forwarding stages; index 0 = youngest (EX/MEM), 1 = MEM/WB, and so on.
- REG_AW, 5, register address width; 2**REG_AW registers.
- LAT_W, 3, width of long-latency countdown; max latency 2**LAT_W-1.
- CNT_W, 32, stall performance counter width.
- SEL_W, $clog2(NUM_FWD+1), derived forward-select width; must not be overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- fwd_we_i  in  NUM_FWD  RegWrite of stage k.
- fwd_rd_i  in  NUM_FWD*REG_AW  destination register of stage k (slice k).
- ex_rs_i  in  NUM_SRC*REG_AW  ID/EX source registers.
- fwd_sel_o  out  NUM_SRC*SEL_W  per-source select: 0 = register file, k+1 = stage k.
- id_rs_i  in  NUM_SRC*REG_AW  IF/ID source registers.
- id_rs_used_i  in  NUM_SRC  source j actually read by the ID instruction.
- idex_memread_i  in  1  instruction in EX is a load.
- idex_rd_i  in  REG_AW  destination of that load.
- mc_issue_i  in  1  long-latency op issues from EX this cycle.
- mc_rd_i  in  REG_AW  its destination.
- mc_lat_i  in  LAT_W  cycles until its regfile write, 1..max.
- stall_o  out  1  freeze PC and IF/ID, bubble into ID/EX.
- sb_busy_o  out  2**REG_AW  scoreboard busy vector.
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Forwarding (combinational, 0 latency):
  - For each source j, fwd_sel_o[j] = k+1 for the lowest k with fwd_we_i[k]=1, fwd_rd_i[k]!=0 and fwd_rd_i[k]==ex_rs_j.
  - Otherwise 0. Youngest stage wins; x0 is never forwarded.
- Load-use: lu_hit = idex_memread_i and idex_rd_i!=0 and there exists j with id_rs_used_i[j] and id_rs_j==idex_rd_i. The bubble clears idex_memread_i next cycle, so lu_hit lasts exactly 1 cycle.
- Scoreboard: one LAT_W down-counter per register; busy = counter!=0.
  - Issue at edge t with rd!=0: counter[rd] <= max(counter[rd]-1 saturating at 0, mc_lat_i). The max preserves WAW ordering.
  - mc_issue_i with mc_rd_i==0 is ignored.
  - All other nonzero counters decrement by 1 per cycle.
  - Issue and decrement on the same register in the same cycle: the issue rule applies.
- sb_hit: there exists j with id_rs_used_i[j] and (sb_busy_o[id_rs_j], or mc_issue_i and mc_rd_i!=0 and id_rs_j==mc_rd_i). Same-cycle issue stalls combinationally.
- stall_o = lu_hit or sb_hit, combinational. The scoreboard keeps counting during stalls.
- stall_cnt_o increments on every cycle with stall_o=1 and saturates at all-ones; no wrap.
- Reset (rst_i=0, async): all counters 0, sb_busy_o=0, stall_cnt_o=0.
  - Combinational outputs follow their inputs even during reset.
  - Reset mid-countdown discards all pending entries.
- Register 0 bit of sb_busy_o is always 0.

Decomposition:
- Shared package (pipeline pkg): REG_AW, fwd select encoding constants FWD_RF=0 / FWD_STAGE_BASE=1, and the max-latency constant.
- One natural sub-module: sb_counter (single-register countdown with max-on-issue).
  - Generated 2**REG_AW times.
  - Remaining logic (priority encoders, compare trees) stays in the parent.

Test Plan:
- Forward priority: NUM_FWD=2, fwd_we=11, fwd_rd={x5,x5}, ex_rs={x5,x6} -> sel[0]=1, sel[1]=0. Then fwd_we=10 -> sel[0]=2. With fwd_rd=x0 and we=11 -> sel=0.
- Load-use: idex_memread=1, idex_rd=x7, id_rs0=x7, used=01 -> stall_o=1 for exactly 1 cycle, stall_cnt_o 0->1. Same with used=00 -> no stall.
- Scoreboard: issue rd=x9, lat=3 at edge t -> busy[9]=1 over cycles t+1..t+3, 0 at t+4. ID reading x9 stalls 3 cycles plus the issue cycle; stall_cnt_o=4.
- WAW max: issue x4 lat=5, then 2 cycles later issue x4 lat=1 -> counter stays 3 (4 remaining minus decrement, max with 1), busy ends at original time.
- Reset mid-op: issue x3 lat=7, assert rst_i low asynchronously between edges -> sb_busy_o=0 and stall_cnt_o=0 immediately. After release, no stall for x3.
- Saturation: CNT_W=4, hold a load-use stall 20 cycles -> stall_cnt_o reaches 15 and holds.
